// File: rtl/simd_mul_pipe.sv
// rtl/simd_mul_pipe.sv - multi-lane 16x16 multiply pipeline with writeback and forwarding taps
module simd_mul_pipe #(
   parameter int LANES     = 4,
   parameter int DEPTH     = 7,
   parameter int FWD_STAGE = DEPTH - 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          stall,
   input  logic                          flush,
   input  logic [0:10]                   op,
   input  logic [2:0]                    format,
   input  logic [0:6]                    rt_addr,
   input  logic [0:32*LANES-1]           ra,
   input  logic [0:32*LANES-1]           rb,
   input  logic [0:32*LANES-1]           rc,
   input  logic [0:17]                   imm,
   input  logic                          reg_write,
   output logic [0:32*LANES-1]           rt_wb,
   output logic [0:6]                    rt_addr_wb,
   output logic                          reg_write_wb,
   output logic [0:32*LANES-1]           rt_fwd,
   output logic [0:6]                    rt_addr_fwd,
   output logic                          reg_write_fwd,
   output logic                          busy,
   output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

   localparam int DW = 32 * LANES;
   localparam int OW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {
      K_NONE,
      K_MPY,
      K_MPYU,
      K_MPYH,
      K_MPYS,
      K_MPYA,
      K_MPYI,
      K_MPYUI
   } kind_t;

   kind_t         kind;
   logic          valid_in;
   logic [0:DW-1] result;
   logic [15:0]   imm16;
   logic [31:0]   a_w;
   logic [31:0]   b_w;
   logic [31:0]   c_w;
   logic [31:0]   s_prod;
   logic [31:0]   lane_res;
   logic [15:0]   a_lo;
   logic [15:0]   a_hi;
   logic [15:0]   b_lo;

   logic [0:DW-1] data_q [1:DEPTH];
   logic [0:6]    addr_q [1:DEPTH];
   logic [1:DEPTH] we_q;
   logic [OW-1:0] occ;

   // Only the low 10 immediate bits feed any op; the upper bits are don't-care.
   logic          unused_imm_hi;
   assign unused_imm_hi = ^imm[0:7];

   // Decode (format, op) into an operation kind; unknown encodings issue a bubble.
   always_comb begin
      kind = K_NONE;
      case (format)
         3'd0: begin
            case (op)
               11'b01111000100: kind = K_MPY;
               11'b01111001100: kind = K_MPYU;
               11'b01111000101: kind = K_MPYH;
               11'b01111000111: kind = K_MPYS;
               default:         kind = K_NONE;
            endcase
         end
         3'd1: begin
            if (op[0:3] == 4'b1100) kind = K_MPYA;
         end
         3'd4: begin
            if (op[0:7] == 8'b01110100)      kind = K_MPYI;
            else if (op[0:7] == 8'b01110101) kind = K_MPYUI;
         end
         default: kind = K_NONE;
      endcase
   end

   assign valid_in = reg_write && (kind != K_NONE) && !flush;

   // Per-lane multiply; every product is kept modulo 2^32, so signed and
   // unsigned forms differ only in how the 16-bit operands are extended.
   always_comb begin
      result   = '0;
      a_w      = '0;
      b_w      = '0;
      c_w      = '0;
      s_prod   = '0;
      lane_res = '0;
      a_lo     = '0;
      a_hi     = '0;
      b_lo     = '0;
      imm16    = {{6{imm[8]}}, imm[8:17]};
      for (int i = 0; i < LANES; i++) begin
         a_w    = ra[32*i +: 32];
         b_w    = rb[32*i +: 32];
         c_w    = rc[32*i +: 32];
         a_lo   = a_w[15:0];
         a_hi   = a_w[31:16];
         b_lo   = b_w[15:0];
         s_prod = {{16{a_lo[15]}}, a_lo} * {{16{b_lo[15]}}, b_lo};
         case (kind)
            K_MPY:   lane_res = s_prod;
            K_MPYU:  lane_res = {16'b0, a_lo} * {16'b0, b_lo};
            K_MPYH:  lane_res = ({16'b0, a_hi} * {16'b0, b_lo}) << 16;
            K_MPYS:  lane_res = {{16{s_prod[31]}}, s_prod[31:16]};
            K_MPYA:  lane_res = s_prod + c_w;
            K_MPYI:  lane_res = {{16{a_lo[15]}}, a_lo} * {{16{imm16[15]}}, imm16};
            K_MPYUI: lane_res = {16'b0, a_lo} * {16'b0, imm16};
            default: lane_res = '0;
         endcase
         result[32*i +: 32] = lane_res;
      end
   end

   // Stage registers: reset and flush clear everything (flush beats stall),
   // stall freezes all stages, otherwise stage 1 captures and the rest shift.
   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         for (int k = 1; k <= DEPTH; k++) begin
            data_q[k] <= '0;
            addr_q[k] <= '0;
         end
         we_q <= '0;
      end else if (!stall) begin
         data_q[1] <= valid_in ? result : '0;
         addr_q[1] <= valid_in ? rt_addr : '0;
         we_q[1]   <= valid_in;
         for (int k = 2; k <= DEPTH; k++) begin
            data_q[k] <= data_q[k-1];
            addr_q[k] <= addr_q[k-1];
            we_q[k]   <= we_q[k-1];
         end
      end
   end

   // Occupancy is a population count of the stage write enables, so it
   // tracks the stage registers edge for edge and cannot exceed DEPTH.
   always_comb begin
      occ = '0;
      for (int k = 1; k <= DEPTH; k++) begin
         occ = occ + OW'(we_q[k]);
      end
   end

   assign rt_wb         = data_q[DEPTH];
   assign rt_addr_wb    = addr_q[DEPTH];
   assign reg_write_wb  = we_q[DEPTH];
   assign rt_fwd        = data_q[FWD_STAGE];
   assign rt_addr_fwd   = addr_q[FWD_STAGE];
   assign reg_write_fwd = we_q[FWD_STAGE];
   assign busy          = |we_q;
   assign occupancy     = occ;

endmodule

// File: tb/tb_simd_mul_pipe.sv
// tb/tb_simd_mul_pipe.sv - directed self-checking bench for simd_mul_pipe
module tb_simd_mul_pipe;

   localparam logic [0:127] RA_V = 128'h00007FFF_FFFFFFFF_000A0009_FFFFFFF5;
   localparam logic [0:127] RB_V = 128'h00008000_00010003_00040005_00060008;
   localparam logic [0:127] RC_V = 128'h00000001_00000010_00000100_FFF60002;
   localparam logic [0:10]  OP_MPY  = 11'b01111000100;
   localparam logic [0:10]  OP_MPYU = 11'b01111001100;
   localparam logic [0:10]  OP_MPYH = 11'b01111000101;
   localparam logic [0:10]  OP_MPYS = 11'b01111000111;
   localparam logic [0:10]  OP_MPYA = 11'b11000101010;
   localparam logic [0:10]  OP_MPYI = 11'b01110100101;
   localparam logic [0:10]  OP_MPYUI = 11'b01110101000;
   localparam logic [0:127] MPY_EXP  = 128'hC0008000_FFFFFFFD_0000002D_FFFFFFA8;
   localparam logic [0:127] MPYU_EXP = 128'h3FFF8000_0002FFFD_0000002D_0007FFA8;
   localparam logic [0:127] MPYA_EXP = 128'hC0008001_0000000D_0000012D_FFF5FFAA;

   logic         clk = 1'b0;
   logic         reset;
   logic         stall;
   logic         flush;
   logic [0:10]  op;
   logic [2:0]   format;
   logic [0:6]   rt_addr;
   logic [0:127] ra;
   logic [0:127] rb;
   logic [0:127] rc;
   logic [0:17]  imm;
   logic         reg_write;
   logic [0:127] rt_wb;
   logic [0:6]   rt_addr_wb;
   logic         reg_write_wb;
   logic [0:127] rt_fwd;
   logic [0:6]   rt_addr_fwd;
   logic         reg_write_fwd;
   logic         busy;
   logic [2:0]   occupancy;

   int n_checks = 0;
   int n_pass   = 0;

   simd_mul_pipe #(.LANES(4), .DEPTH(7), .FWD_STAGE(6)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .op(op),
      .format(format), .rt_addr(rt_addr), .ra(ra), .rb(rb), .rc(rc),
      .imm(imm), .reg_write(reg_write), .rt_wb(rt_wb), .rt_addr_wb(rt_addr_wb),
      .reg_write_wb(reg_write_wb), .rt_fwd(rt_fwd), .rt_addr_fwd(rt_addr_fwd),
      .reg_write_fwd(reg_write_fwd), .busy(busy), .occupancy(occupancy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reg_write = 1'b0;
      stall     = 1'b0;
      flush     = 1'b0;
      op        = '0;
      format    = 3'd0;
      rt_addr   = '0;
      imm       = '0;
      ra        = RA_V;
      rb        = RB_V;
      rc        = '0;
   endtask

   task automatic issue_mpy(input logic [0:6] addr);
      reg_write = 1'b1;
      format    = 3'd0;
      op        = OP_MPY;
      rt_addr   = addr;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0; stall = 1'b1; flush = 1'b1; reg_write = 1'b1; op = OP_MPY;
      tick();
      tick();
      n_checks++; if (reg_write_wb !== 1'b0) $display("FAIL reset_we_wb got %b want 0", reg_write_wb); else n_pass++;
      n_checks++; if (rt_wb !== '0) $display("FAIL reset_rt_wb got %h want 0", rt_wb); else n_pass++;
      n_checks++; if (rt_addr_wb !== '0) $display("FAIL reset_addr_wb got %h want 0", rt_addr_wb); else n_pass++;
      n_checks++; if (reg_write_fwd !== 1'b0) $display("FAIL reset_we_fwd got %b want 0", reg_write_fwd); else n_pass++;
      n_checks++; if (rt_fwd !== '0) $display("FAIL reset_rt_fwd got %h want 0", rt_fwd); else n_pass++;
      n_checks++; if (occupancy !== 3'd0) $display("FAIL reset_occ got %0d want 0", occupancy); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
      idle_inputs();
      reset = 1'b1;
   endtask

   task automatic test_ops();
      logic [2:0]   fmt;
      logic [0:10]  opc;
      logic [0:127] rcv;
      logic [0:17]  immv;
      logic [0:127] exp;
      logic         exp_we;
      logic [0:6]   exp_addr;
      for (int v = 0; v < 10; v++) begin
         fmt = 3'd0; rcv = '0; immv = '0; exp_we = 1'b1;
         case (v)
            0: begin opc = OP_MPY;  exp = MPY_EXP; end
            1: begin opc = OP_MPYU; exp = MPYU_EXP; end
            2: begin opc = OP_MPYH; exp = 128'h00000000_FFFD0000_00320000_FFF80000; end
            3: begin opc = OP_MPYS; exp = 128'hFFFFC000_FFFFFFFF_00000000_FFFFFFFF; end
            4: begin fmt = 3'd1; opc = OP_MPYA; rcv = RC_V; exp = MPYA_EXP; end
            5: begin fmt = 3'd4; opc = OP_MPYI; immv = 18'd42;
                      exp = 128'h0014FFD6_FFFFFFD6_0000017A_FFFFFE32; end
            6: begin fmt = 3'd4; opc = OP_MPYI; immv = 18'h3FFFE;
                      exp = 128'hFFFF0002_00000002_FFFFFFEE_00000016; end
            7: begin fmt = 3'd4; opc = OP_MPYUI; immv = 18'h3FFFE;
                      exp = 128'h7FFE0002_FFFD0002_0008FFEE_FFF30016; end
            8: begin opc = 11'b01111000110; exp = '0; exp_we = 1'b0; end
            default: begin fmt = 3'd2; opc = OP_MPYI; immv = 18'd42; exp = '0; exp_we = 1'b0; end
         endcase
         exp_addr = exp_we ? 7'(20 + v) : 7'd0;
         ra = RA_V; rb = RB_V; rc = rcv; imm = immv; op = opc; format = fmt;
         rt_addr = 7'(20 + v); reg_write = 1'b1;
         for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) begin
               reg_write = 1'b0;
               ra = '0; rb = '0; rc = '0;
            end
            n_checks++;
            if (reg_write_wb !== (exp_we && t == 7))
               $display("FAIL op%0d_we_wb t=%0d got %b want %b", v, t, reg_write_wb, exp_we && t == 7);
            else n_pass++;
            if (t == 6) begin
               n_checks++;
               if (reg_write_fwd !== exp_we || rt_fwd !== exp)
                  $display("FAIL op%0d_fwd got we=%b %h want we=%b %h", v, reg_write_fwd, rt_fwd, exp_we, exp);
               else n_pass++;
            end
            if (t == 7) begin
               n_checks++;
               if (rt_wb !== exp) $display("FAIL op%0d_rt_wb got %h want %h", v, rt_wb, exp); else n_pass++;
               n_checks++;
               if (rt_addr_wb !== exp_addr) $display("FAIL op%0d_addr_wb got %0d want %0d", v, rt_addr_wb, exp_addr); else n_pass++;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      int         peak;
      logic [31:0] exp_lane;
      peak = 0;
      for (int t = 1; t <= 14; t++) begin
         if (t <= 6) begin
            reg_write = 1'b1; format = 3'd4; op = OP_MPYI; ra = RA_V;
            imm = 18'(t); rt_addr = 7'(t);
         end else begin
            reg_write = 1'b0;
         end
         tick();
         if (int'(occupancy) > peak) peak = int'(occupancy);
         n_checks++;
         if (reg_write_wb !== (t >= 7 && t <= 12))
            $display("FAIL b2b_we_wb t=%0d got %b want %b", t, reg_write_wb, (t >= 7 && t <= 12));
         else n_pass++;
         if (t >= 7 && t <= 12) begin
            exp_lane = 32'(9 * (t - 6));
            n_checks++;
            if (rt_addr_wb !== 7'(t - 6) || rt_wb[64 +: 32] !== exp_lane)
               $display("FAIL b2b_data t=%0d got addr=%0d lane2=%h want addr=%0d lane2=%h",
                        t, rt_addr_wb, rt_wb[64 +: 32], t - 6, exp_lane);
            else n_pass++;
         end
      end
      n_checks++; if (peak !== 6) $display("FAIL b2b_peak_occ got %0d want 6", peak); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL b2b_drained_busy got %b want 0", busy); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_stall();
      for (int t = 1; t <= 13; t++) begin
         case (t)
            1: issue_mpy(7'd10);
            2: begin issue_mpy(7'd11); op = OP_MPYU; end
            3: begin stall = 1'b1; issue_mpy(7'd12); end
            6: begin stall = 1'b0; reg_write = 1'b0; end
            default: ;
         endcase
         tick();
         if (t >= 3 && t <= 5) begin
            n_checks++;
            if (occupancy !== 3'd2) $display("FAIL stall_occ t=%0d got %0d want 2", t, occupancy); else n_pass++;
         end
         n_checks++;
         if (reg_write_wb !== (t == 10 || t == 11))
            $display("FAIL stall_we_wb t=%0d got %b want %b", t, reg_write_wb, (t == 10 || t == 11));
         else n_pass++;
         if (t == 10) begin
            n_checks++;
            if (rt_addr_wb !== 7'd10 || rt_wb !== MPY_EXP)
               $display("FAIL stall_first got addr=%0d %h want addr=10 %h", rt_addr_wb, rt_wb, MPY_EXP);
            else n_pass++;
         end
         if (t == 11) begin
            n_checks++;
            if (rt_addr_wb !== 7'd11 || rt_wb !== MPYU_EXP)
               $display("FAIL stall_second got addr=%0d %h want addr=11 %h", rt_addr_wb, rt_wb, MPYU_EXP);
            else n_pass++;
         end
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      for (int s = 0; s < 2; s++) begin
         for (int t = 1; t <= 12; t++) begin
            if (t <= 4) issue_mpy(7'(t));
            else if (t == 5) begin flush = 1'b1; stall = s[0]; issue_mpy(7'd5); end
            else begin flush = 1'b0; stall = 1'b0; reg_write = 1'b0; end
            tick();
            if (t == 4) begin
               n_checks++;
               if (occupancy !== 3'd4) $display("FAIL flush%0d_pre_occ got %0d want 4", s, occupancy); else n_pass++;
            end
            if (t == 5) begin
               n_checks++;
               if (occupancy !== 3'd0 || busy !== 1'b0)
                  $display("FAIL flush%0d_occ got occ=%0d busy=%b want 0 0", s, occupancy, busy);
               else n_pass++;
            end
            if (t >= 5) begin
               n_checks++;
               if ({reg_write_wb, reg_write_fwd} !== 2'b00 || rt_fwd !== '0 || rt_wb !== '0)
                  $display("FAIL flush%0d_quiet t=%0d got we=%b%b fwd=%h wb=%h want all 0",
                           s, t, reg_write_wb, reg_write_fwd, rt_fwd, rt_wb);
               else n_pass++;
            end
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_midstream();
      for (int t = 1; t <= 12; t++) begin
         if (t <= 3) issue_mpy(7'(t));
         else if (t == 4) begin reset = 1'b0; stall = 1'b1; issue_mpy(7'd4); end
         else if (t == 5) begin
            reset = 1'b1; stall = 1'b0; issue_mpy(7'd33);
            format = 3'd1; op = OP_MPYA; rc = RC_V;
         end else reg_write = 1'b0;
         tick();
         if (t == 4) begin
            n_checks++;
            if (occupancy !== 3'd0 || busy !== 1'b0 || {reg_write_wb, reg_write_fwd} !== 2'b00 ||
                rt_wb !== '0 || rt_fwd !== '0 || rt_addr_wb !== '0 || rt_addr_fwd !== '0)
               $display("FAIL midreset_clear got occ=%0d busy=%b we=%b%b addr=%0d/%0d want all 0",
                        occupancy, busy, reg_write_wb, reg_write_fwd, rt_addr_wb, rt_addr_fwd);
            else n_pass++;
         end
         n_checks++;
         if (reg_write_wb !== (t == 11))
            $display("FAIL midreset_we_wb t=%0d got %b want %b", t, reg_write_wb, (t == 11));
         else n_pass++;
         if (t == 11) begin
            n_checks++;
            if (rt_addr_wb !== 7'd33 || rt_wb !== MPYA_EXP)
               $display("FAIL midreset_result got addr=%0d %h want addr=33 %h", rt_addr_wb, rt_wb, MPYA_EXP);
            else n_pass++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      test_reset();
      test_ops();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
